ccu: RTL and testbench



---
 rtl/ccu_pkg.sv | 98 +++++++++
 rtl/ccu_decode.sv | 33 +++
 rtl/ccu.sv | 31 +++
 tb/tb_ccu.sv | 104 ++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// ccu_pkg: shared field layout, opcodes and control-word constants for the command control unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Optional build macro CCU_ILLEGAL_TRAP_EN selects the word produced for illegal commands.
// Fields a_sel, b_sel, sp_inc, sp_dec, irq_ack and reserved are never driven, so no
// positions are defined for them here.
package ccu_pkg;

    localparam int KBUS_W = 24;

    // field bit positions
    localparam int ALU_OP_LSB = 20;   // [23:20]
    localparam int ALU_OP_W   = 4;
    localparam int WB_SEL_LSB = 14;   // [15:14]
    localparam int WB_SEL_W   = 2;

    // single-bit strobes
    localparam logic [KBUS_W-1:0] BIT_REG_WE   = 24'(1) << 13;
    localparam logic [KBUS_W-1:0] BIT_MEM_RD   = 24'(1) << 12;
    localparam logic [KBUS_W-1:0] BIT_MEM_WR   = 24'(1) << 11;
    localparam logic [KBUS_W-1:0] BIT_PIX_WR   = 24'(1) << 10;
    localparam logic [KBUS_W-1:0] BIT_PIX_RD   = 24'(1) << 9;
    localparam logic [KBUS_W-1:0] BIT_PC_LOAD  = 24'(1) << 8;
    localparam logic [KBUS_W-1:0] BIT_PC_INC   = 24'(1) << 7;
    localparam logic [KBUS_W-1:0] BIT_FLAGS_WE = 24'(1) << 6;
    localparam logic [KBUS_W-1:0] BIT_HALT     = 24'(1) << 2;
    localparam logic [KBUS_W-1:0] BIT_ILLEGAL  = 24'(1) << 1;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHL  = 4'd6
    } alu_op_t;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU   = 2'd0,
        WB_MEM   = 2'd1,
        WB_PIXEL = 2'd2
    } wb_sel_t;

    // opcodes
    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_LD   = 8'h02;
    localparam logic [7:0] CMD_ST   = 8'h04;
    localparam logic [7:0] CMD_ADD  = 8'h06;
    localparam logic [7:0] CMD_SUB  = 8'h08;
    localparam logic [7:0] CMD_AND  = 8'h0A;
    localparam logic [7:0] CMD_OR   = 8'h0C;
    localparam logic [7:0] CMD_XOR  = 8'h0E;
    localparam logic [7:0] CMD_SHL  = 8'h10;
    localparam logic [7:0] CMD_CMP  = 8'h12;
    localparam logic [7:0] CMD_JMP  = 8'h14;
    localparam logic [7:0] CMD_PIXW = 8'h16;
    localparam logic [7:0] CMD_PIXR = 8'h18;
    localparam logic [7:0] CMD_HALT = 8'h4C;

    function automatic logic [KBUS_W-1:0] alu_f(input alu_op_t op);
        return KBUS_W'(op) << ALU_OP_LSB;
    endfunction

    function automatic logic [KBUS_W-1:0] wb_f(input wb_sel_t sel);
        return KBUS_W'(sel) << WB_SEL_LSB;
    endfunction

    // arithmetic ops share the same write-back/flags/advance pattern
    localparam logic [KBUS_W-1:0] ARITH = BIT_REG_WE | BIT_FLAGS_WE | BIT_PC_INC;

    localparam logic [KBUS_W-1:0] KBUS_NOP  = BIT_PC_INC;                                        // 0x000080
    localparam logic [KBUS_W-1:0] KBUS_LD   = wb_f(WB_MEM) | BIT_REG_WE | BIT_MEM_RD | BIT_PC_INC; // 0x007080
    localparam logic [KBUS_W-1:0] KBUS_ST   = BIT_MEM_WR | BIT_PC_INC;                           // 0x000880
    localparam logic [KBUS_W-1:0] KBUS_ADD  = alu_f(ALU_ADD) | ARITH;                            // 0x1020C0
    localparam logic [KBUS_W-1:0] KBUS_SUB  = alu_f(ALU_SUB) | ARITH;                            // 0x2020C0
    localparam logic [KBUS_W-1:0] KBUS_AND  = alu_f(ALU_AND) | ARITH;                            // 0x3020C0
    localparam logic [KBUS_W-1:0] KBUS_OR   = alu_f(ALU_OR)  | ARITH;                            // 0x4020C0
    localparam logic [KBUS_W-1:0] KBUS_XOR  = alu_f(ALU_XOR) | ARITH;                            // 0x5020C0
    localparam logic [KBUS_W-1:0] KBUS_SHL  = alu_f(ALU_SHL) | ARITH;                            // 0x6020C0
    // compare is a subtract that only updates flags
    localparam logic [KBUS_W-1:0] KBUS_CMP  = alu_f(ALU_SUB) | BIT_FLAGS_WE | BIT_PC_INC;        // 0x2000C0
    localparam logic [KBUS_W-1:0] KBUS_JMP  = alu_f(ALU_NONE) | BIT_PC_LOAD;                     // 0x000100
    localparam logic [KBUS_W-1:0] KBUS_PIXW = BIT_PIX_WR | BIT_PC_INC;                           // 0x000480
    localparam logic [KBUS_W-1:0] KBUS_PIXR = wb_f(WB_PIXEL) | BIT_REG_WE | BIT_PIX_RD | BIT_PC_INC; // 0x00A280
    localparam logic [KBUS_W-1:0] KBUS_HALT = wb_f(WB_ALU) | BIT_HALT;                           // 0x000004

    // all-zero word: no datapath action
    localparam logic [KBUS_W-1:0] KBUS_RESET = '0;

`ifdef CCU_ILLEGAL_TRAP_EN
    localparam logic [KBUS_W-1:0] KBUS_ILLEGAL = BIT_HALT | BIT_ILLEGAL;                         // 0x000006
`else
    // illegal commands quietly behave as NOP
    localparam logic [KBUS_W-1:0] KBUS_ILLEGAL = KBUS_NOP;
`endif

endpackage

// File: rtl/ccu_decode.sv
// ccu_decode: combinational ROM from command byte to 24-bit control word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows cmd continuously.
// Ports: cmd [7:0] in, word [23:0] out. Illegal-command word set by CCU_ILLEGAL_TRAP_EN (see ccu_pkg).
module ccu_decode
    import ccu_pkg::*;
(
    input  logic [7:0]        cmd,
    output logic [KBUS_W-1:0] word
);

    always_comb begin
        word = KBUS_ILLEGAL;
        case (cmd)
            CMD_NOP:  word = KBUS_NOP;
            CMD_LD:   word = KBUS_LD;
            CMD_ST:   word = KBUS_ST;
            CMD_ADD:  word = KBUS_ADD;
            CMD_SUB:  word = KBUS_SUB;
            CMD_AND:  word = KBUS_AND;
            CMD_OR:   word = KBUS_OR;
            CMD_XOR:  word = KBUS_XOR;
            CMD_SHL:  word = KBUS_SHL;
            CMD_CMP:  word = KBUS_CMP;
            CMD_JMP:  word = KBUS_JMP;
            CMD_PIXW: word = KBUS_PIXW;
            CMD_PIXR: word = KBUS_PIXR;
            CMD_HALT: word = KBUS_HALT;
            default:  word = KBUS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ccu.sv
// ccu: command control unit, registers the decoded control word onto Kbus.
// Latency: 1 cycle from the cmd sampling edge to Kbus.
// Backpressure: none; a new command is accepted every cycle.
// Ports: clk, rst (sync, active-high), cmd [7:0] in, Kbus [23:0] out.
// Build macro CCU_ILLEGAL_TRAP_EN: illegal commands trap (halt+illegal) instead of acting as NOP.
module ccu
    import ccu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd,
    output logic [23:0] Kbus
);

    logic [KBUS_W-1:0] dec_word;

    ccu_decode u_decode (
        .cmd  (cmd),
        .word (dec_word)
    );

    // reset wins over the command sampled at the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            Kbus <= KBUS_RESET;
        end else begin
            Kbus <= dec_word;
        end
    end

endmodule

// File: tb/tb_ccu.sv
// tb_ccu: directed self-checking bench for ccu.
// Latency: expects Kbus one edge after cmd is sampled.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ccu;

    logic        clk;
    logic        rst;
    logic [7:0]  cmd;
    logic [23:0] Kbus;

    int n_checks = 0;
    int n_errors = 0;

    ccu dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd),
        .Kbus (Kbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
        end
    endtask

    // apply inputs, take one edge, sample 1ns later
    task automatic step(input logic r, input logic [7:0] c);
        rst = r;
        cmd = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  sweep_cmd [12];
    logic [23:0] sweep_exp [12];
    logic [23:0] ill_exp;

    initial begin
        sweep_cmd = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C,
                      8'h0E, 8'h10, 8'h12, 8'h14, 8'h16, 8'h18};
        sweep_exp = '{24'h007080, 24'h000880, 24'h1020C0, 24'h2020C0, 24'h3020C0, 24'h4020C0,
                      24'h5020C0, 24'h6020C0, 24'h2000C0, 24'h000100, 24'h000480, 24'h00A280};
`ifdef CCU_ILLEGAL_TRAP_EN
        ill_exp = 24'h000006;
`else
        ill_exp = 24'h000080;
`endif

        rst = 1'b1;
        cmd = 8'h06;
        @(negedge clk);

        // reset held over two edges with an ADD presented
        step(1'b1, 8'h06); check("reset_edge1", Kbus, 24'h000000);
        step(1'b1, 8'h06); check("reset_edge2", Kbus, 24'h000000);
        step(1'b0, 8'h06); check("release_add", Kbus, 24'h1020C0);

        // legal opcode sweep on consecutive edges
        for (int i = 0; i < 12; i++) begin
            step(1'b0, sweep_cmd[i]);
            check($sformatf("sweep_%02h", sweep_cmd[i]), Kbus, sweep_exp[i]);
        end
        step(1'b0, 8'h00); check("nop", Kbus, 24'h000080);

        // halt is not sticky
        step(1'b0, 8'h4C); check("halt", Kbus, 24'h000004);
        step(1'b0, 8'h02); check("ld_after_halt", Kbus, 24'h007080);

        // illegal commands: odd, all-ones, unused even
        step(1'b0, 8'h03); check("illegal_03", Kbus, ill_exp);
        step(1'b0, 8'hFF); check("illegal_ff", Kbus, ill_exp);
        step(1'b0, 8'h4E); check("illegal_4e", Kbus, ill_exp);
        step(1'b0, 8'h1A); check("illegal_1a", Kbus, ill_exp);

        // repeated command gives identical word
        step(1'b0, 8'h0E); check("repeat_1", Kbus, 24'h5020C0);
        step(1'b0, 8'h0E); check("repeat_2", Kbus, 24'h5020C0);

        // mid-stream reset overrides the command sampled at that edge
        step(1'b0, 8'h06); check("mid_add", Kbus, 24'h1020C0);
        step(1'b1, 8'h08); check("mid_rst", Kbus, 24'h000000);
        step(1'b0, 8'h08); check("mid_sub", Kbus, 24'h2020C0);

        // glitch on cmd between edges must not reach Kbus
        step(1'b0, 8'h00); check("hold_pre", Kbus, 24'h000080);
        #2 cmd = 8'h14;
        #2 cmd = 8'h00;
        check("hold_mid", Kbus, 24'h000080);
        @(posedge clk);
        #1;
        check("hold_post", Kbus, 24'h000080);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
